ctrl_pipe_decoder: RTL
======================

CTRL_PIPE_DECODER -- requirements
Module: ctrl_pipe_decoder

Interface
REQ-001 Parameter ENABLE_M, default 1: 1 decodes RV32M ops; 0 marks them illegal.
REQ-002 Parameter MUL_LAT, default 4: issue-block cycles after an accepted MUL-class op (range 1..63).
REQ-003 Parameter DIV_LAT, default 33: issue-block cycles after an accepted DIV/REM-class op (range 1..63).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  instr is valid.
REQ-007 instr  in  32  raw instruction; bits [6:0] opcode, [14:12] funct3, [31:25] funct7.
REQ-008 in_ready  out  1  block accepts instr this cycle.
REQ-009 out_valid  out  1  registered control bundle is valid.
REQ-010 out_ready  in  1  execute stage consumes bundle.
REQ-011 flush  in  1  discard held bundle (branch redirect).
REQ-012 branch, mem_read, mem_write, alu_src, reg_write  out  1 each  registered control bits.
REQ-013 mem_to_reg  out  2  writeback select: 00 ALU, 01 memory, 10 upper-imm/PC, 11 PC+4.
REQ-014 alu_op  out  3  class: 000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110 load, 111 JALR.
REQ-015 md_op  out  1  bundle is an M-extension op; md_div  out  1  funct3[2] of that op.
REQ-016 illegal  out  1  opcode/funct7 not decodable.
REQ-017 md_busy  out  1  issue blocked by multi-cycle M op.

Function
REQ-018 Decode: 0110011 funct7 0000000/0100000 -> R, alu_src 0, reg_write 1; funct7 0000001 with ENABLE_M=1 -> same plus md_op 1.
REQ-019 Decode: 0010011 -> I, alu_src 1, reg_write 1; 0000011 -> load, mem_read 1, mem_to_reg 01, alu_src 1, reg_write 1.
REQ-020 Decode: 0100011 -> S, mem_write 1, alu_src 1, reg_write 0; 1100011 -> B, branch 1, alu_src 0, reg_write 0.
REQ-021 Decode: 0010111 and 0110111 -> U, mem_to_reg 10, alu_src 1, reg_write 1; 1101111 -> J, 1100111 -> JALR, both mem_to_reg 11, alu_src 1, reg_write 1.
REQ-022 Any other opcode/funct7 -> all control bits 0, alu_op 000, illegal 1; bundle still passes handshake.
REQ-023 Accept when in_valid && in_ready; bundle registered, out_valid 1 next cycle (latency 1).
REQ-024 in_ready = (!out_valid || out_ready) && state==RUN && !flush; full-throughput when out_ready held 1.
REQ-025 Bundle and out_valid hold stable while out_valid && !out_ready.
REQ-026 FSM states RUN, MD_WAIT; RUN -> MD_WAIT when a bundle with md_op=1 is consumed (out_valid && out_ready), loading counter with LAT-1 (DIV_LAT if md_div else MUL_LAT).
REQ-027 MD_WAIT: counter decrements each cycle; at 0 -> RUN same edge; LAT=1 returns to RUN after one cycle; md_busy = (state==MD_WAIT).
REQ-028 flush clears out_valid next edge, blocks acceptance that cycle, does not alter FSM or counter.
REQ-029 flush and out_ready same cycle on an M bundle: consumption wins, MD_WAIT entered, out_valid cleared.

Reset
REQ-030 rst asserted: out_valid 0, all control outputs 0, illegal 0, md_busy 0, state RUN, counter 0, immediately and independent of clk.
REQ-031 rst mid-MD_WAIT aborts the wait; first post-reset edge may accept.

Structure
REQ-032 Opcode constants, alu_op class codes, mem_to_reg codes, and FSM state enum live in shared package riscv_ctrl_pkg.
REQ-033 Combinational decode is one sub-module, ctrl_decode_comb; this block adds handshake register, FSM, counter.

Verification
REQ-034 instr 0x00B50533 (add) with out_ready 1 -> next cycle out_valid 1, alu_op 000, reg_write 1, md_op 0; back-to-back adds flow every cycle.
REQ-035 instr 0x02B50533 (mul), MUL_LAT 4 -> after consume md_busy 1 for exactly 4 cycles, in_ready 0 throughout.
REQ-036 instr 0x02B54533 (div), DIV_LAT 33 -> md_busy 33 cycles; ENABLE_M=0 build -> illegal 1, md_op 0.
REQ-037 out_ready 0 for 5 cycles with beq 0x00B50463 held -> bundle stable, branch 1, reg_write 0, in_ready 0; flush -> out_valid 0 next cycle.
REQ-038 rst pulsed asynchronously mid-div wait -> all outputs 0 before next edge, RUN, next instr accepted.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I/M control-decode constants, FSM state encoding and control bundle type.
// No logic; imported by the decoder and its handshake wrapper.
// Backpressure: n/a.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] ALU_R    = 3'b000;
    localparam logic [2:0] ALU_I    = 3'b001;
    localparam logic [2:0] ALU_S    = 3'b010;
    localparam logic [2:0] ALU_B    = 3'b011;
    localparam logic [2:0] ALU_U    = 3'b100;
    localparam logic [2:0] ALU_J    = 3'b101;
    localparam logic [2:0] ALU_LOAD = 3'b110;
    localparam logic [2:0] ALU_JALR = 3'b111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_UPC = 2'b10;
    localparam logic [1:0] WB_PC4 = 2'b11;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_t;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [2:0] alu_op;
        logic       md_op;
        logic       md_div;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purpose: purely combinational opcode/funct7 decode into a control bundle.
// Latency: 0 cycles.
// Backpressure: none; the caller registers and handshakes the result.
module ctrl_decode_comb
    import riscv_ctrl_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic       funct3_hi,
    output ctrl_t      ctrl_dat
);

    always_comb begin
        ctrl_dat = '0;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    ctrl_dat.alu_op    = ALU_R;
                    ctrl_dat.reg_write = 1'b1;
                end else if (ENABLE_M != 0 && funct7 == F7_MULDIV) begin
                    ctrl_dat.alu_op    = ALU_R;
                    ctrl_dat.reg_write = 1'b1;
                    ctrl_dat.md_op     = 1'b1;
                    ctrl_dat.md_div    = funct3_hi;
                end else begin
                    ctrl_dat.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                ctrl_dat.alu_op    = ALU_I;
                ctrl_dat.alu_src   = 1'b1;
                ctrl_dat.reg_write = 1'b1;
            end
            OP_LOAD: begin
                ctrl_dat.alu_op     = ALU_LOAD;
                ctrl_dat.mem_read   = 1'b1;
                ctrl_dat.mem_to_reg = WB_MEM;
                ctrl_dat.alu_src    = 1'b1;
                ctrl_dat.reg_write  = 1'b1;
            end
            OP_STORE: begin
                ctrl_dat.alu_op    = ALU_S;
                ctrl_dat.mem_write = 1'b1;
                ctrl_dat.alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_dat.alu_op = ALU_B;
                ctrl_dat.branch = 1'b1;
            end
            OP_AUIPC, OP_LUI: begin
                ctrl_dat.alu_op     = ALU_U;
                ctrl_dat.mem_to_reg = WB_UPC;
                ctrl_dat.alu_src    = 1'b1;
                ctrl_dat.reg_write  = 1'b1;
            end
            OP_JAL: begin
                ctrl_dat.alu_op     = ALU_J;
                ctrl_dat.mem_to_reg = WB_PC4;
                ctrl_dat.alu_src    = 1'b1;
                ctrl_dat.reg_write  = 1'b1;
            end
            OP_JALR: begin
                ctrl_dat.alu_op     = ALU_JALR;
                ctrl_dat.mem_to_reg = WB_PC4;
                ctrl_dat.alu_src    = 1'b1;
                ctrl_dat.reg_write  = 1'b1;
            end
            default: ctrl_dat.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_decoder.sv
// Purpose: registered decode stage with valid/ready handshake and M-op issue blocking.
// Latency: 1 cycle from accepted instr to out_valid.
// Backpressure: bundle held while !out_ready; issue blocked during flush and MUL/DIV wait.
module ctrl_pipe_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        flush,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic [1:0]  mem_to_reg,
    output logic [2:0]  alu_op,
    output logic        md_op,
    output logic        md_div,
    output logic        illegal,
    output logic        md_busy
);

    localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

    ctrl_t      dec_dat;
    ctrl_t      bundle_q;
    md_state_t  state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       accept_vld;
    logic       consume_vld;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^{instr[24:15], instr[13:7]};

    ctrl_decode_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .opcode    (instr[6:0]),
        .funct7    (instr[31:25]),
        .funct3_hi (instr[14]),
        .ctrl_dat  (dec_dat)
    );

    assign in_ready    = (!out_valid || out_ready) && (state_q == RUN) && !flush;
    assign accept_vld  = in_valid && in_ready;
    assign consume_vld = out_valid && out_ready;

    // A consume and a new accept in the same cycle simply replace the bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            bundle_q  <= '0;
        end else if (accept_vld) begin
            out_valid <= 1'b1;
            bundle_q  <= dec_dat;
        end else if (consume_vld || flush) begin
            out_valid <= 1'b0;
            bundle_q  <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Wait starts when the M bundle leaves, even if a flush arrives that same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (consume_vld && bundle_q.md_op) begin
                    state_d = MD_WAIT;
                    cnt_d   = bundle_q.md_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            MD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign md_busy    = (state_q == MD_WAIT);
    assign branch     = bundle_q.branch;
    assign mem_read   = bundle_q.mem_read;
    assign mem_write  = bundle_q.mem_write;
    assign alu_src    = bundle_q.alu_src;
    assign reg_write  = bundle_q.reg_write;
    assign mem_to_reg = bundle_q.mem_to_reg;
    assign alu_op     = bundle_q.alu_op;
    assign md_op      = bundle_q.md_op;
    assign md_div     = bundle_q.md_div;
    assign illegal    = bundle_q.illegal;

endmodule
